// File: rtl/softmax_pkg.sv
// Shared types and helpers for the attention-score / softmax pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum for the row buffer stage, default score saturation
// bounds, and the sat_to_data() clamp used by the requant lane, the row-max
// subtractor and the softmax stage itself.
package softmax_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default score width of the softmax datapath and its saturation bounds.
    localparam int SM_DATA_WIDTH = 8;
    localparam logic signed [SM_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(SM_DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SM_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(SM_DATA_WIDTH-1){1'b1}}};

    // Width of the intermediate carried into sat_to_data(); callers sign-extend
    // their wide signed value to this width and truncate the result to dw bits.
    localparam int WIDE_W = 64;

    // Clamp a wide signed value into the signed range of a dw-bit number.
    function automatic logic signed [WIDE_W-1:0] sat_to_data(
        input logic signed [WIDE_W-1:0] v,
        input int unsigned              dw
    );
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] hi;
        lo = -(64'sd1 <<< (dw - 1));
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/attn_score_premax_requant_lane.sv
// Requantizer: signed acc x unsigned scale, round half up, arithmetic shift, saturate to DATA_WIDTH.
// Latency: product registered 1 cycle after in_vld; rounded/saturated result is combinational from
//          that register and is meant to be captured by the caller (the row buffer is pipe stage 2).
// Backpressure: none; every in_vld beat emerges exactly one cycle later, caller must always accept.
//
// Ports: clk_p/rst_n clock and async active-low reset; in_vld/acc/scale/tag_in input beat with an
//        opaque sideband tag; out_vld/out_dat/tag_out the requantized beat and its tag.
module attn_score_premax_requant_lane
    import softmax_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int MULT_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT      = 8,
    parameter int TAG_WIDTH  = 1
) (
    input  logic                         clk_p,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [MULT_WIDTH-1:0] scale,
    input  logic        [TAG_WIDTH-1:0]  tag_in,
    output logic                         out_vld,
    output logic signed [DATA_WIDTH-1:0] out_dat,
    output logic        [TAG_WIDTH-1:0]  tag_out
);

    // One extra bit so the unsigned multiplier can be treated as signed.
    localparam int PW = ACC_WIDTH + MULT_WIDTH + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (SHIFT - 1);

    logic signed [PW-1:0] acc_x;
    logic signed [PW-1:0] scl_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic                 vld_q;
    logic [TAG_WIDTH-1:0] tag_q;

    always_comb begin
        acc_x = PW'(acc);
        scl_x = PW'($signed({1'b0, scale}));
        prod  = acc_x * scl_x;
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            prod_q <= '0;
            tag_q  <= '0;
        end else begin
            vld_q <= in_vld;
            if (in_vld) begin
                prod_q <= prod;
                tag_q  <= tag_in;
            end
        end
    end

    // The product magnitude stays below 2^(PW-2), so adding the rounding bias cannot overflow.
    always_comb begin
        rounded = prod_q + RND;
        shifted = rounded >>> SHIFT;
        out_dat = DATA_WIDTH'(sat_to_data(WIDE_W'(shifted), DATA_WIDTH));
        out_vld = vld_q;
        tag_out = tag_q;
    end

endmodule

// File: rtl/attn_score_premax.sv
// Softmax pre-stage: requantize a row of QK^T accumulators, buffer it, replay it as (score - row_max) <= 0.
// Latency: first output valid 3 cycles after the last element of a row is accepted, then 1 element/cycle.
// Backpressure: output register holds under out_ready=0; input stalled (in_ready=0) for whole WAIT/DRAIN.
//
// Ports: clk_p, rst_n (async active-low); scale_mult sampled with each row's first element;
//        acc_in/in_valid_n(active low)/in_ready input stream; score_out/out_valid_n(active low)/out_ready
//        output stream with out_row_last and out_mat_last qualifiers.
// Build option: define CAUSAL_MASK_EN to mask elements with col > row (forced to min, excluded from row max).
module attn_score_premax
    import softmax_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MULT_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter int ROW_LEN    = 128,
    parameter int ROW_NUM    = 128
) (
    input  logic                         clk_p,
    input  logic                         rst_n,
    input  logic        [MULT_WIDTH-1:0] scale_mult,
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    input  logic                         in_valid_n,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] score_out,
    output logic                         out_valid_n,
    input  logic                         out_ready,
    output logic                         out_row_last,
    output logic                         out_mat_last
);

    localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                         state;
    state_t                         state_nxt;
    logic        [IDX_W-1:0]        col;
    logic        [IDX_W-1:0]        rd_idx;
    logic        [ROW_W-1:0]        row;
    logic        [MULT_WIDTH-1:0]   scale_q;
    logic                           wait_cnt;
    logic signed [DATA_WIDTH-1:0]   row_max;
    logic signed [DATA_WIDTH-1:0]   row_buf [ROW_LEN];
    logic                           out_vld;

    logic                           accept;
    logic                           col_last;
    logic        [MULT_WIDTH-1:0]   scale_cur;
    logic                           masked;
    logic                           lane_vld;
    logic signed [DATA_WIDTH-1:0]   lane_dat;
    logic        [IDX_W:0]          lane_tag;
    logic                           lane_masked;
    logic        [IDX_W-1:0]        lane_col;
    logic                           xfer;
    logic                           drain_done;
    logic                           load;
    logic        [IDX_W-1:0]        ld_idx;
    logic                           ld_last;
    logic signed [DATA_WIDTH:0]     diff;
    logic signed [DATA_WIDTH-1:0]   ld_score;

    // ---------------- input side ----------------
    always_comb begin
        accept   = (state == FILL) && !in_valid_n;
        col_last = (col == IDX_W'(ROW_LEN - 1));
        // First element of a row uses the live multiplier; the rest reuse the latched one.
        scale_cur = (col == '0) ? scale_mult : scale_q;
`ifdef CAUSAL_MASK_EN
        masked = (int'(col) > int'(row));
`else
        masked = 1'b0;
`endif
    end

    attn_score_premax_requant_lane #(
        .ACC_WIDTH  (ACC_WIDTH),
        .MULT_WIDTH (MULT_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT),
        .TAG_WIDTH  (IDX_W + 1)
    ) u_lane (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .in_vld  (accept),
        .acc     (acc_in),
        .scale   (scale_cur),
        .tag_in  ({masked, col}),
        .out_vld (lane_vld),
        .out_dat (lane_dat),
        .tag_out (lane_tag)
    );

    assign lane_masked = lane_tag[IDX_W];
    assign lane_col    = lane_tag[IDX_W-1:0];

    // Row buffer: one write port fed by the lane, one read port for the drain.
    always_ff @(posedge clk_p) begin
        if (lane_vld) begin
            row_buf[lane_col] <= lane_masked ? D_MIN : lane_dat;
        end
    end

    // ---------------- output side ----------------
    always_comb begin
        xfer       = out_vld && out_ready;
        drain_done = (state == DRAIN) && xfer && out_row_last;
        // Element 0 is loaded on the last WAIT cycle, later ones as each transfer frees the register.
        load       = ((state == WAIT) && wait_cnt) ||
                     ((state == DRAIN) && xfer && !out_row_last);
        ld_idx     = (state == WAIT) ? '0 : rd_idx;
        ld_last    = (ld_idx == IDX_W'(ROW_LEN - 1));
        // One extra bit keeps (masked min - row_max) representable before the clamp.
        diff       = {row_buf[ld_idx][DATA_WIDTH-1], row_buf[ld_idx]} -
                     {row_max[DATA_WIDTH-1], row_max};
        ld_score   = DATA_WIDTH'(sat_to_data(WIDE_W'(diff), DATA_WIDTH));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (accept && col_last) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Cycle 1 lets the final product reach the buffer, cycle 2 sees the final row_max.
                if (wait_cnt) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // ---------------- counters, row max and output register ----------------
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            col          <= '0;
            rd_idx       <= '0;
            row          <= '0;
            scale_q      <= '0;
            wait_cnt     <= 1'b0;
            row_max      <= D_MIN;
            out_vld      <= 1'b0;
            score_out    <= '0;
            out_row_last <= 1'b0;
            out_mat_last <= 1'b0;
        end else begin
            if (accept) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col == '0) begin
                    scale_q <= scale_mult;
                end
            end

            wait_cnt <= (state == WAIT) ? ~wait_cnt : 1'b0;

            if (lane_vld && !lane_masked && (lane_dat > row_max)) begin
                row_max <= lane_dat;
            end

            if (load) begin
                out_vld      <= 1'b1;
                score_out    <= ld_score;
                out_row_last <= ld_last;
                out_mat_last <= ld_last && (row == ROW_W'(ROW_NUM - 1));
                rd_idx       <= ld_idx + 1'b1;
            end else if (xfer) begin
                out_vld      <= 1'b0;
                out_row_last <= 1'b0;
                out_mat_last <= 1'b0;
            end

            if (drain_done) begin
                row_max <= D_MIN;
                row     <= (row == ROW_W'(ROW_NUM - 1)) ? '0 : row + 1'b1;
            end
        end
    end

    assign out_valid_n = ~out_vld;

endmodule

// File: tb/tb_attn_score_premax.sv
// Bench for attn_score_premax with ROW_LEN=4, ROW_NUM=2: random rows checked against a plain-arithmetic row model.
// Latency: n/a.
// Backpressure: drives out_ready fixed, dropped, or randomized per scenario.
module tb_attn_score_premax;

    localparam int ACC_WIDTH  = 32;
    localparam int DATA_WIDTH = 8;
    localparam int MULT_WIDTH = 16;
    localparam int SHIFT      = 8;
    localparam int ROW_LEN    = 4;
    localparam int ROW_NUM    = 2;

    logic                         clk_p = 1'b0;
    logic                         rst_n = 1'b1;
    logic        [MULT_WIDTH-1:0] scale_mult = '0;
    logic signed [ACC_WIDTH-1:0]  acc_in = '0;
    logic                         in_valid_n = 1'b1;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] score_out;
    logic                         out_valid_n;
    logic                         out_ready = 1'b1;
    logic                         out_row_last;
    logic                         out_mat_last;

    attn_score_premax #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MULT_WIDTH (MULT_WIDTH),
        .SHIFT      (SHIFT),
        .ROW_LEN    (ROW_LEN),
        .ROW_NUM    (ROW_NUM)
    ) dut (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .scale_mult   (scale_mult),
        .acc_in       (acc_in),
        .in_valid_n   (in_valid_n),
        .in_ready     (in_ready),
        .score_out    (score_out),
        .out_valid_n  (out_valid_n),
        .out_ready    (out_ready),
        .out_row_last (out_row_last),
        .out_mat_last (out_mat_last)
    );

    always #5 clk_p = ~clk_p;

    typedef longint acc_row_t [ROW_LEN];
    typedef struct {
        logic signed [DATA_WIDTH-1:0] s;
        logic                         rl;
        logic                         ml;
    } obs_t;

    obs_t got_q [$];
    obs_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   model_row = 0;
    bit   rdy_rand = 0;

    // Record every transfer: sampled mid-cycle, it completes on the next rising edge.
    always @(negedge clk_p) begin
        if (rst_n === 1'b1 && out_valid_n === 1'b0 && out_ready === 1'b1) begin
            obs_t o;
            o.s  = score_out;
            o.rl = out_row_last;
            o.ml = out_mat_last;
            got_q.push_back(o);
        end
    end

    always @(posedge clk_p) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Row model: round-half-up requant, saturate, optional causal mask, then subtract the row max.
    function automatic void model_calc(input acc_row_t a, input int unsigned scale, input int row,
                                       output int e [ROW_LEN]);
        int     q [ROW_LEN];
        int     mx;
        longint r;
        bit     m;
        mx = -128;
        for (int k = 0; k < ROW_LEN; k++) begin
            r = (a[k] * longint'(scale) + 128) >>> 8;
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
            m = 1'b0;
`ifdef CAUSAL_MASK_EN
            m = (k > row);
`endif
            q[k] = m ? -128 : int'(r);
            if (!m && q[k] > mx) mx = q[k];
        end
        for (int k = 0; k < ROW_LEN; k++) begin
            e[k] = (q[k] - mx < -128) ? -128 : q[k] - mx;
        end
    endfunction

    task automatic expect_row(input acc_row_t a, input int unsigned scale);
        int   e [ROW_LEN];
        obs_t o;
        model_calc(a, scale, model_row, e);
        for (int k = 0; k < ROW_LEN; k++) begin
            o.s  = e[k][7:0];
            o.rl = (k == ROW_LEN - 1);
            o.ml = (k == ROW_LEN - 1) && (model_row == ROW_NUM - 1);
            exp_q.push_back(o);
        end
        model_row = (model_row + 1) % ROW_NUM;
    endtask

    // Called and returns #1 after a rising edge; returns right after the last element's accept edge.
    task automatic send_row(input acc_row_t a, input int unsigned scale, input bit gaps);
        for (int k = 0; k < ROW_LEN; k++) begin
            bit ok;
            int n;
            if (gaps) begin
                in_valid_n = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk_p); #1; end
            end
            in_valid_n = 1'b0;
            acc_in     = a[k][31:0];
            scale_mult = (k == 0) ? scale[15:0] : 16'($urandom);
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk_p);
                ok = (in_ready === 1'b1);
                @(posedge clk_p); #1;
                n++;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL send_row timeout elem %0d: in_ready=%b required 1", k, in_ready);
            end
        end
        in_valid_n = 1'b1;
        acc_in     = '0;
    endtask

    task automatic wait_outputs(input int n);
        int c = 0;
        while (got_q.size() < n && c < 400) begin @(posedge clk_p); #1; c++; end
        repeat (3) begin @(posedge clk_p); #1; end
    endtask

    task automatic rand_row(output acc_row_t a);
        for (int k = 0; k < ROW_LEN; k++) begin
            case ($urandom_range(0, 3))
                0: a[k] = longint'($urandom_range(0, 2000)) - 1000;
                1: a[k] = longint'($signed($urandom)) >>> $urandom_range(0, 31);
                2: a[k] = 0;
                default: a[k] = (longint'($urandom_range(0, 8)) - 4) * 256;
            endcase
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        total += 5;
        if (in_ready !== 1'b1)     begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        if (out_valid_n !== 1'b1)  begin bad++; $display("FAIL reset out_valid_n: got %b want 1", out_valid_n); end
        if (score_out !== 8'sd0)   begin bad++; $display("FAIL reset score_out: got %0d want 0", score_out); end
        if (out_row_last !== 1'b0) begin bad++; $display("FAIL reset out_row_last: got %b want 0", out_row_last); end
        if (out_mat_last !== 1'b0) begin bad++; $display("FAIL reset out_mat_last: got %b want 0", out_mat_last); end
        repeat (2) @(posedge clk_p);
        #1 rst_n = 1'b1;
        @(posedge clk_p); #1;
        model_row = 0;
    endtask

    task automatic test_basic;
        acc_row_t a;
        int lat;
        bit rdy_low;
        a = '{256, 512, -256, 0};
        out_ready = 1'b1;
        expect_row(a, 64);
        send_row(a, 64, 1'b0);
        lat = 0;
        rdy_low = 1'b1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk_p);
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            if (out_valid_n === 1'b0) lat = i;
        end
        total += 2;
        if (lat != 3) begin bad++; $display("FAIL basic latency: got %0d cycles want 3", lat); end
        if (!rdy_low) begin bad++; $display("FAIL basic in_ready during wait: got 1 want 0"); end
        @(posedge clk_p); #1;
        wait_outputs(ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL basic count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL basic[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL basic[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic in_ready after drain: got %b want 1", in_ready); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_rounding;
        acc_row_t a;
        a = '{3, -3, 1, 0};
        expect_row(a, 128);
        send_row(a, 128, 1'b1);
        wait_outputs(ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL round count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL round[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL round[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        acc_row_t a, b;
        int sa, sb, low_cnt, size_at_rise;
        rand_row(a); rand_row(b);
        sa = $urandom_range(1, 65535);
        sb = $urandom_range(1, 65535);
        out_ready = 1'b1;
        expect_row(a, sa);
        expect_row(b, sb);
        send_row(a, sa, 1'b0);
        low_cnt = 0;
        size_at_rise = -1;
        fork
            send_row(b, sb, 1'b0);
            begin
                for (int i = 0; i < 40 && size_at_rise < 0; i++) begin
                    @(negedge clk_p);
                    if (in_ready === 1'b1) size_at_rise = got_q.size();
                    else low_cnt++;
                end
            end
        join
        total += 2;
        if (low_cnt != 6) begin bad++; $display("FAIL b2b in_ready low cycles: got %0d want 6", low_cnt); end
        if (size_at_rise != ROW_LEN) begin bad++; $display("FAIL b2b drained at in_ready rise: got %0d want %0d", size_at_rise, ROW_LEN); end
        wait_outputs(2 * ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL b2b[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL b2b[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure;
        acc_row_t a;
        int s, n;
        obs_t snap;
        rand_row(a);
        s = $urandom_range(1, 65535);
        out_ready = 1'b1;
        expect_row(a, s);
        send_row(a, s, 1'b0);
        n = 0;
        while (out_valid_n !== 1'b0 && n < 20) begin @(negedge clk_p); n++; end
        @(posedge clk_p); #1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_p);
            total += 2;
            if (in_ready !== 1'b0)    begin bad++; $display("FAIL bp in_ready cyc %0d: got %b want 0", j, in_ready); end
            if (out_valid_n !== 1'b0) begin bad++; $display("FAIL bp out_valid_n cyc %0d: got %b want 0", j, out_valid_n); end
            if (j == 0) begin
                snap.s = score_out; snap.rl = out_row_last; snap.ml = out_mat_last;
            end else begin
                total++;
                if (score_out !== snap.s || out_row_last !== snap.rl || out_mat_last !== snap.ml) begin
                    bad++;
                    $display("FAIL bp hold cyc %0d: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", j,
                             score_out, out_row_last, out_mat_last, snap.s, snap.rl, snap.ml);
                end
            end
        end
        @(posedge clk_p); #1;
        out_ready = 1'b1;
        wait_outputs(ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL bp[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL bp[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        acc_row_t a;
        int s;
        rdy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            rand_row(a);
            s = $urandom_range(0, 65535);
            expect_row(a, s);
            send_row(a, s, 1'($urandom_range(0, 1)));
        end
        wait_outputs(8 * ROW_LEN);
        rdy_rand = 1'b0;
        @(posedge clk_p); #2;
        out_ready = 1'b1;
        wait_outputs(8 * ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL rand[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL rand[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_drain;
        acc_row_t a;
        int s, n;
        rand_row(a);
        s = $urandom_range(1, 65535);
        out_ready = 1'b1;
        send_row(a, s, 1'b0);
        n = 0;
        while (out_valid_n !== 1'b0 && n < 20) begin @(negedge clk_p); n++; end
        @(posedge clk_p); #1;
        #1 rst_n = 1'b0;
        #1;
        total += 3;
        if (out_valid_n !== 1'b1)  begin bad++; $display("FAIL rst_drain out_valid_n: got %b want 1", out_valid_n); end
        if (in_ready !== 1'b1)     begin bad++; $display("FAIL rst_drain in_ready: got %b want 1", in_ready); end
        if (out_row_last !== 1'b0) begin bad++; $display("FAIL rst_drain out_row_last: got %b want 0", out_row_last); end
        @(posedge clk_p); #1;
        rst_n = 1'b1;
        @(negedge clk_p);
        total += 2;
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_release in_ready: got %b want 1", in_ready); end
        if (out_valid_n !== 1'b1) begin bad++; $display("FAIL rst_release out_valid_n: got %b want 1", out_valid_n); end
        @(posedge clk_p); #1;
        got_q.delete(); exp_q.delete();
        model_row = 0;
        rand_row(a);
        s = $urandom_range(1, 65535);
        expect_row(a, s);
        send_row(a, s, 1'b0);
        wait_outputs(ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_next count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL rst_next[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL rst_next[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    // Constant rows of 10 at unity scale: every element ties with the max unless masked.
    task automatic test_mask;
        acc_row_t a;
        int tab [8];
        obs_t o;
`ifdef CAUSAL_MASK_EN
        tab = '{0, -128, -128, -128, 0, 0, -128, -128};
`else
        tab = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        @(posedge clk_p); #1 rst_n = 1'b0;
        @(posedge clk_p); #1 rst_n = 1'b1;
        got_q.delete(); exp_q.delete();
        model_row = 0;
        a = '{10, 10, 10, 10};
        for (int i = 0; i < 8; i++) begin
            o.s  = tab[i][7:0];
            o.rl = (i % ROW_LEN == ROW_LEN - 1);
            o.ml = (i == 7);
            exp_q.push_back(o);
        end
        send_row(a, 256, 1'b0);
        send_row(a, 256, 1'b0);
        wait_outputs(2 * ROW_LEN);
        total++;
        if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mask count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size()) begin bad++; $display("FAIL mask[%0d] missing: want s=%0d", i, exp_q[i].s); end
            else if (got_q[i].s !== exp_q[i].s || got_q[i].rl !== exp_q[i].rl || got_q[i].ml !== exp_q[i].ml) begin
                bad++;
                $display("FAIL mask[%0d]: got s=%0d rl=%b ml=%b want s=%0d rl=%b ml=%b", i,
                         got_q[i].s, got_q[i].rl, got_q[i].ml, exp_q[i].s, exp_q[i].rl, exp_q[i].ml);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_drain();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
